// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes, memory freeze, timeout trap.
// Latency: hazard controls are combinational (same cycle); state, flags and counters are registered.
// Backpressure: a data-memory stall freezes PC, IF/ID and downstream stages until ready returns.
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             ctrl_bubble_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             pipe_stall_o,
    output logic             timeout_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] waitCnt;
    logic              memStall;
    logic              loadUse;
    logic              active;
    logic              waitExpired;

    assign memStall    = dmem_req_i & ~dmem_ready_i;
    assign loadUse     = ex_memread_i & (ex_rd_i != 5'd0) &
                         ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
    assign active      = (state == RUN) | (state == MEMWAIT);
    assign waitExpired = memStall & (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign state_o     = state;

    always_comb begin
        ctrl_bubble_o = 1'b0;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        pipe_stall_o  = 1'b0;
        case (state)
            IDLE: begin
                ctrl_bubble_o = 1'b1;
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
            end
            ERROR: begin
                ctrl_bubble_o = 1'b1;
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                pipe_stall_o  = 1'b1;
            end
            default: begin
                // A load-use hazard masks the branch; it re-resolves once the load advances.
                if (memStall) begin
                    pipe_stall_o = 1'b1;
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                end else if (loadUse) begin
                    ctrl_bubble_o = 1'b1;
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                end else if (branch_taken_i) begin
                    ifid_flush_o = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            waitCnt      <= '0;
            timeout_o    <= 1'b0;
            bubble_cnt_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    waitCnt <= '0;
                    if (start_i) state <= RUN;
                end
                RUN, MEMWAIT: begin
                    if (waitExpired) begin
                        state     <= ERROR;
                        timeout_o <= 1'b1;
                    end else if (memStall) begin
                        state <= MEMWAIT;
                    end else begin
                        state <= RUN;
                    end
                    waitCnt <= memStall ? waitCnt + WAIT_W'(1) : '0;
                end
                default: begin
                    waitCnt <= '0;
                end
            endcase

            if (active && memStall && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (active && !memStall && loadUse && bubble_cnt_o != '1)
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: vector table plus hand-written timeout and boundary sequences.
module tb_hazard_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
    logic        ex_memread_i, branch_taken_i, dmem_req_i, dmem_ready_i;
    logic        ctrl_bubble_o, pc_write_o, ifid_write_o, ifid_flush_o, pipe_stall_o, timeout_o;
    logic [1:0]  state_o;
    logic [15:0] bubble_cnt_o, stall_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    hazard_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .ex_rd_i(ex_rd_i),
        .ex_memread_i(ex_memread_i), .branch_taken_i(branch_taken_i),
        .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .ctrl_bubble_o(ctrl_bubble_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .ifid_flush_o(ifid_flush_o), .pipe_stall_o(pipe_stall_o), .timeout_o(timeout_o),
        .state_o(state_o), .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        logic       rst, start;
        logic [4:0] rd, rs1, rs2;
        logic       mr, br, req, rdy;
        logic       bub, pcw, ifw, fl, stl;
        logic [1:0] st;
        logic       to;
        int         bc, sc;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mkv(input logic rst, start, input int rd, rs1, rs2,
                                 input logic mr, br, req, rdy,
                                 input logic bub, pcw, ifw, fl, stl, input int st,
                                 input logic to, input int bc, sc);
        vec_t v;
        v.rst = rst; v.start = start; v.rd = rd[4:0]; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0];
        v.mr = mr; v.br = br; v.req = req; v.rdy = rdy;
        v.bub = bub; v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.stl = stl;
        v.st = st[1:0]; v.to = to; v.bc = bc; v.sc = sc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, start, input logic [4:0] rd, rs1, rs2,
                         input logic mr, br, req, rdy);
        rst_i = rst; start_i = start; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        ex_memread_i = mr; branch_taken_i = br; dmem_req_i = req; dmem_ready_i = rdy;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic bub, pcw, ifw, fl, stl,
                           input int st, input logic to, input int bc, sc);
        chk({tag, ".bubble"}, idx, int'(ctrl_bubble_o), int'(bub));
        chk({tag, ".pc_write"}, idx, int'(pc_write_o), int'(pcw));
        chk({tag, ".ifid_write"}, idx, int'(ifid_write_o), int'(ifw));
        chk({tag, ".flush"}, idx, int'(ifid_flush_o), int'(fl));
        chk({tag, ".stall"}, idx, int'(pipe_stall_o), int'(stl));
        chk({tag, ".state"}, idx, int'(state_o), st);
        chk({tag, ".timeout"}, idx, int'(timeout_o), int'(to));
        chk({tag, ".bubble_cnt"}, idx, int'(bubble_cnt_o), bc);
        chk({tag, ".stall_cnt"}, idx, int'(stall_cnt_o), sc);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //               rst st rd rs1 rs2 mr br rq rdy  bub pcw ifw fl stl st to bc sc
        tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 0, 3, 1, 2, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mkv(0, 0, 5, 1, 5, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[4]  = mkv(0, 0, 5, 1, 5, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 0, 1, 0);
        tbl[5]  = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 1, 0, 1, 0);
        tbl[6]  = mkv(0, 0, 7, 7, 2, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[7]  = mkv(0, 0, 7, 1, 2, 0, 1, 0, 0,  0, 1, 1, 1, 0, 1, 0, 2, 0);
        tbl[8]  = mkv(0, 0, 5, 5, 2, 1, 1, 1, 0,  0, 0, 0, 0, 1, 1, 0, 2, 0);
        tbl[9]  = mkv(0, 0, 5, 5, 2, 1, 1, 1, 0,  0, 0, 0, 0, 1, 2, 0, 2, 1);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 2, 0, 2, 2);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 2, 0, 2, 3);
        tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 0, 2, 3);
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 1, 0, 2, 3);
        tbl[14] = mkv(0, 0, 9, 9, 2, 1, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0, 2, 3);
        tbl[15] = mkv(1, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0, 3, 3);
        tbl[16] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].mr, tbl[i].br, tbl[i].req, tbl[i].rdy);
            #2;
            chk_all("vec", i, tbl[i].bub, tbl[i].pcw, tbl[i].ifw, tbl[i].fl, tbl[i].stl,
                    int'(tbl[i].st), tbl[i].to, tbl[i].bc, tbl[i].sc);
            tick();
        end

        // Hung memory: 16 stall cycles, branch and load-use masked throughout.
        for (int c = 1; c <= 16; c++) begin
            drive(0, 0, 5, 5, 0, 1, 1, 1, 0);
            #2;
            chk("hang.stall", c, int'(pipe_stall_o), 1);
            chk("hang.bubble", c, int'(ctrl_bubble_o), 0);
            chk("hang.flush", c, int'(ifid_flush_o), 0);
            chk("hang.state", c, int'(state_o), (c == 1) ? 1 : 2);
            chk("hang.timeout", c, int'(timeout_o), 0);
            tick();
        end
        for (int c = 0; c < 50; c++) begin
            drive(0, c[0], 0, 0, 0, 0, c[1], c[2], c[3]);
            #2;
            chk_all("err", c, 1, 0, 0, 0, 1, 3, 1, 0, 16);
            tick();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("post_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Ready arriving on the 16th stall cycle must not trap.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int c = 1; c <= 16; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, (c == 16) ? 1'b1 : 1'b0);
            #2;
            chk("edge.stall", c, int'(pipe_stall_o), (c == 16) ? 0 : 1);
            chk("edge.state", c, int'(state_o), (c == 1) ? 1 : 2);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("edge.after", 0, 0, 1, 1, 0, 0, 1, 0, 0, 15);
        tick();
        #2;
        chk("edge.hold_state", 0, int'(state_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall controller for the 5-stage pipelined CPU. Detects load-use hazards between ID and EX, resolves taken-branch flushes in ID, and freezes the whole pipeline while the data memory is not ready. Drives the select input of the control-signal bubble mux in ID, plus PC and IF/ID write enables. A watchdog traps a hung data memory into a sticky error state.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-stall cycles that trigger ERROR; legal range 2..255.
- CNT_W, 16: width of the performance counters.

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  leave IDLE and begin fetching
- id_rs1_i  in  5  ID-stage source register 1
- id_rs2_i  in  5  ID-stage source register 2
- ex_rd_i  in  5  EX-stage destination register
- ex_memread_i  in  1  EX-stage instruction is a load
- branch_taken_i  in  1  branch resolved taken in ID
- dmem_req_i  in  1  MEM stage is accessing data memory
- dmem_ready_i  in  1  data memory completes access this cycle
- ctrl_bubble_o  out  1  select for bubble mux (1 = zero all ID control signals)
- pc_write_o  out  1  PC register write enable
- ifid_write_o  out  1  IF/ID register write enable
- ifid_flush_o  out  1  clear IF/ID to NOP
- pipe_stall_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- timeout_o  out  1  sticky memory-timeout flag
- state_o  out  2  current state (IDLE=0, RUN=1, MEMWAIT=2, ERROR=3)
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted, saturating
- stall_cnt_o  out  CNT_W  memory-stall cycles, saturating

## Operation
- Internal terms, combinational:
  - memstall = dmem_req_i & ~dmem_ready_i
  - loaduse = ex_memread_i & (ex_rd_i != 0) & (ex_rd_i == id_rs1_i | ex_rd_i == id_rs2_i)
- IDLE:
  - Outputs: ctrl_bubble_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, pipe_stall_o=0.
  - start_i=1 -> RUN.
- RUN and MEMWAIT share the same priority-resolved outputs.
  - Default: ctrl_bubble_o=0, pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, pipe_stall_o=0.
  - Priority 1, memstall: pipe_stall_o=1, pc_write_o=0, ifid_write_o=0. Bubble and flush stay 0.
  - Priority 2, loaduse without memstall: ctrl_bubble_o=1, pc_write_o=0, ifid_write_o=0. Branch is ignored; it re-resolves next cycle.
  - Priority 3, branch_taken_i alone: ifid_flush_o=1, pc_write_o=1.
- Transitions:
  - RUN -> MEMWAIT on memstall.
  - MEMWAIT -> RUN when memstall=0, including when dmem_req_i drops.
  - Timeout from either state -> ERROR.
- Wait counter:
  - Width ceil(log2(MEM_TIMEOUT)).
  - Increments on every memstall cycle; clears on any cycle without memstall.
  - When memstall=1 and the counter equals MEM_TIMEOUT-1, next state is ERROR and timeout_o sets.
- ERROR:
  - Outputs: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1, ctrl_bubble_o=1, ifid_flush_o=0.
  - Only rst_i exits ERROR.
- Counters:
  - bubble_cnt_o increments on each priority-2 cycle.
  - stall_cnt_o increments on each memstall cycle in RUN or MEMWAIT.
  - Both saturate at 2^CNT_W-1 and never wrap.
- rd=x0 never causes a load-use stall.

## Timing
- All datapath-facing outputs are combinational from current state and inputs (Mealy), so they act in the same cycle as the hazard.
- state_o, timeout_o, counters and wait counter are registered.
- Reset (rst_i high at a rising edge), including mid-stall or in ERROR:
  - State -> IDLE; timeout_o, counters and wait counter -> 0.
  - Outputs after reset: ctrl_bubble_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, pipe_stall_o=0, state_o=0.
  - rst_i has priority over start_i.
- Latency:
  - Load-use costs exactly 1 bubble cycle: the load moves to MEM next cycle, so loaduse clears.
  - A memory access ready in its first cycle costs 0 stall cycles.
- MEM_TIMEOUT=16 with ready never asserted: stall cycles 1..16, then state_o=3 from cycle 17.
- Ready on the 16th stall cycle means no memstall that cycle, so no timeout. This is the boundary case.

## Test plan
- Reset, then start_i one cycle:
  - While start_i is low: state_o=0, pc_write_o=0, ctrl_bubble_o=1.
  - Next cycle: state_o=1, pc_write_o=1, ctrl_bubble_o=0.
- Load-use, ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, for one cycle:
  - That cycle: ctrl_bubble_o=1, pc_write_o=0, ifid_write_o=0; bubble_cnt_o=1 next cycle.
  - Repeat with ex_rd_i=0: no bubble.
- Taken branch with loaduse in the same cycle:
  - Only ctrl_bubble_o=1, ifid_flush_o=0.
  - Next cycle, loaduse clear, branch still taken: ifid_flush_o=1.
- dmem_req_i=1 with dmem_ready_i low 3 cycles, then high:
  - pipe_stall_o=1 for 3 cycles; state_o=2 on cycles 2-3 of the stall, RUN after ready; stall_cnt_o=3.
  - Branch and loaduse asserted during the stall: no bubble or flush.
- Ready never asserted, MEM_TIMEOUT=16:
  - After 16 stall cycles: state_o=3, timeout_o=1, held for 50 cycles.
  - rst_i for one cycle -> state_o=0, timeout_o=0.
- Ready asserted on the 16th stall cycle:
  - No ERROR; state returns to 1; stall_cnt_o=15.
